// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, beq/j redirect and stall.
// Ports: clk_i/rst_i, start_i, imem_addr_o/imem_data_i, stall_i,
//   branch_i/eq_i/jump_i, pc_o, if_id_instr_o/pc4_o/valid_o, fetch_cnt_o.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             eq_i,
  input  logic             jump_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '0;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  if_id_t           ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        jump_tk;
  logic        br_tk;
  logic        do_stall;
  logic        do_jump;
  logic        do_br;
  logic        do_fetch;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;

  assign pc4      = pc_q + 32'd4;
  // Redirects only count when the IF/ID slot holds a real instruction.
  assign jump_tk  = jump_i & ifid_q.valid;
  assign br_tk    = branch_i & eq_i & ifid_q.valid;
  assign jump_tgt = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
  assign br_off   = {{14{ifid_q.instr[15]}}, ifid_q.instr[15:0], 2'b00};
  assign br_tgt   = ifid_q.pc4 + br_off;

  // One-hot action select: stall > jump > branch > fetch.
  assign do_stall = stall_i;
  assign do_jump  = ~stall_i & jump_tk;
  assign do_br    = ~stall_i & ~jump_tk & br_tk;
  assign do_fetch = ~stall_i & ~jump_tk & ~br_tk;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        unique case (1'b1)
          do_stall: begin
          end
          do_jump: begin
            pc_d   = jump_tgt;
            ifid_d = BUBBLE;
          end
          do_br: begin
            pc_d   = br_tgt;
            ifid_d = BUBBLE;
          end
          do_fetch: begin
            pc_d         = pc4;
            ifid_d.instr = imem_data_i;
            ifid_d.pc4   = pc4;
            ifid_d.valid = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
          end
          default: begin
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_instr_o = ifid_q.instr;
  assign if_id_pc4_o   = ifid_q.pc4;
  assign if_id_valid_o = ifid_q.valid;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps plus random traffic vs a model.
// Second instance at a high RESET_PC exercises the jump target nibble.
module tb_fetch_stage;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        branch_i;
  logic        eq_i;
  logic        jump_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [3:0]  fetch_cnt_o;

  logic        h_start;
  logic        h_jump;
  logic [31:0] h_addr;
  logic [31:0] h_data;
  logic [31:0] h_pc;
  logic [31:0] h_instr;
  logic [31:0] h_pc4;
  logic        h_valid;
  logic [15:0] h_cnt;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .stall_i(stall_i), .branch_i(branch_i), .eq_i(eq_i),
    .jump_i(jump_i), .pc_o(pc_o), .if_id_instr_o(if_id_instr_o),
    .if_id_pc4_o(if_id_pc4_o), .if_id_valid_o(if_id_valid_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  fetch_stage #(.RESET_PC(32'h4000_0008), .CNT_W(16)) dut_hi (
    .clk_i(clk), .rst_i(rst_i), .start_i(h_start),
    .imem_addr_o(h_addr), .imem_data_i(h_data),
    .stall_i(1'b0), .branch_i(1'b0), .eq_i(1'b0),
    .jump_i(h_jump), .pc_o(h_pc), .if_id_instr_o(h_instr),
    .if_id_pc4_o(h_pc4), .if_id_valid_o(h_valid),
    .fetch_cnt_o(h_cnt)
  );

  assign h_data = (h_addr == 32'h4000_000C) ? 32'h0800_0040 : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  bit          rnd_mem = 0;

  bit          m_run;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  int          m_cnt;

  function automatic logic [31:0] memrd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (rnd_mem) begin
      mem[a] = $urandom;
      return mem[a];
    end
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_instr = 32'h0;
    m_pc4 = 32'h0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic model_edge(bit st, bit sl, bit br, bit e, bit jp,
                            logic [31:0] d);
    if (!m_run) begin
      m_run = st;
      return;
    end
    if (sl) return;
    if (jp && m_valid) begin
      m_pc = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (br && e && m_valid) begin
      m_pc = m_pc4 + (32'($signed(m_instr[15:0])) << 2);
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      m_instr = d;
      m_pc4 = m_pc + 32'd4;
      m_valid = 1;
      m_pc = m_pc + 32'd4;
      m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".addr"}, imem_addr_o, m_pc);
    chk({tag, ".instr"}, if_id_instr_o, m_instr);
    chk({tag, ".pc4"}, if_id_pc4_o, m_pc4);
    chk({tag, ".valid"}, 32'(if_id_valid_o), 32'(m_valid));
    chk({tag, ".cnt"}, 32'(fetch_cnt_o), 32'(m_cnt));
  endtask

  task automatic step(string tag, bit st, bit sl, bit br, bit e, bit jp);
    logic [31:0] d;
    start_i = st; stall_i = sl; branch_i = br; eq_i = e; jump_i = jp;
    imem_data_i = memrd(imem_addr_o);
    d = memrd(m_pc);
    @(posedge clk);
    model_edge(st, sl, br, e, jp, d);
    #1;
    check_all(tag);
  endtask

  task automatic chk_hi(string tag, logic [31:0] pc, logic [31:0] ins,
                        logic [31:0] p4, bit v, int c);
    chk({tag, ".pc"}, h_pc, pc);
    chk({tag, ".instr"}, h_instr, ins);
    chk({tag, ".pc4"}, h_pc4, p4);
    chk({tag, ".valid"}, 32'(h_valid), 32'(v));
    chk({tag, ".cnt"}, 32'(h_cnt), 32'(c));
  endtask

  initial begin
    rst_i = 0; start_i = 0; stall_i = 0; branch_i = 0;
    eq_i = 0; jump_i = 0; imem_data_i = 0;
    h_start = 0; h_jump = 0;
    mem[32'd12] = 32'h1000_0003;
    mem[32'd28] = 32'h1000_0003;
    mem[32'd32] = 32'h1000_FFF6;
    model_reset();
    #12;
    check_all("reset");
    chk_hi("hi_reset", 32'h4000_0008, 0, 0, 0, 0);
    rst_i = 1;

    // Main DUT idles while the high-PC instance runs its jump test.
    h_start = 1;
    step("idle0", 0, 0, 0, 0, 0);
    chk_hi("hi_start", 32'h4000_0008, 0, 0, 0, 0);
    h_start = 0;
    step("idle1", 0, 1, 1, 1, 1);
    chk_hi("hi_f1", 32'h4000_000C, 0, 32'h4000_000C, 1, 1);
    step("idle2", 0, 0, 0, 0, 0);
    chk_hi("hi_f2", 32'h4000_0010, 32'h0800_0040, 32'h4000_0010, 1, 2);
    h_jump = 1;
    step("idle3", 0, 0, 0, 0, 0);
    chk_hi("hi_jump", 32'h4000_0100, 0, 0, 0, 2);
    step("idle4", 0, 0, 0, 0, 0);
    chk_hi("hi_nojump", 32'h4000_0104, 0, 32'h4000_0104, 1, 3);
    h_jump = 0;

    step("start", 1, 0, 0, 0, 0);
    step("f0", 0, 0, 0, 0, 0);
    step("f4", 1, 0, 0, 0, 0);
    step("stall0", 0, 1, 0, 0, 0);
    step("stall1", 0, 1, 0, 0, 0);
    step("f8", 0, 0, 0, 0, 0);
    step("f12", 0, 0, 0, 0, 0);
    step("beq_stall", 0, 1, 1, 1, 0);
    step("beq_taken", 0, 0, 1, 1, 0);
    chk("beq_tgt", pc_o, 32'd28);
    step("bubble_br", 0, 0, 1, 1, 0);
    step("beq_nt", 0, 0, 1, 0, 0);
    step("beq_back", 0, 0, 1, 1, 0);
    chk("beq_neg", pc_o, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 0);
    chk("pc_wrap", pc_o, 32'h0);
    step("f0b", 0, 0, 0, 0, 0);
    step("jmp_br", 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step("run5", 0, 0, 0, 0, 0);

    #2 rst_i = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst_i = 1;
    step("post_rst0", 0, 0, 0, 0, 0);
    step("post_rst1", 0, 0, 1, 1, 1);
    step("restart", 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step("cnt16", 0, 0, 0, 0, 0);
    chk("cnt_wrap", 32'(fetch_cnt_o), 32'h0);

    rnd_mem = 1;
    for (int i = 0; i < 300; i++) begin
      step("rnd",
           1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 3,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 19) < 3);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
